// File: rtl/acc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// acc_rr_arbiter
//
// Lets NREQ requesters share one in-order streaming accelerator.
//
// Input side: a two-state FSM (IDLE/XFER) picks one requester at a time in
// round-robin order. It then locks onto that requester and passes its beats
// straight through to the accelerator for JOB_BEATS handshakes. Each grant is
// recorded in a tag FIFO when the job starts.
//
// Output side: the accelerator returns results in job-start order. The FIFO
// head tag therefore tells us which requester owns the current result beat.
// After OUT_BEATS result handshakes the head is popped.
//
// Ports
//   clk_core, rst_core   : single clock, asynchronous active-high reset
//   req_tdata/tvalid/    : NREQ requester input streams (128-bit slice each)
//     tready
//   m_tdata/tvalid/tready: muxed job stream towards the accelerator
//   s_tdata/tvalid/tready: result stream coming back from the accelerator
//   rsp_tdata            : result data, broadcast to every requester
//   rsp_tvalid/tready    : per-requester result handshake, one-hot by owner
//   busy                 : a job is being fed, or results are still owed
//
// TAG_DEPTH must be a power of two and at least 2. The FIFO pointers wrap
// naturally at that depth.
// ---------------------------------------------------------------------------
module acc_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int JOB_BEATS = 16,
    parameter int OUT_BEATS = 16,
    parameter int TAG_DEPTH = 8
) (
    input  logic                clk_core,
    input  logic                rst_core,
    input  logic [NREQ*128-1:0] req_tdata,
    input  logic [NREQ-1:0]     req_tvalid,
    output logic [NREQ-1:0]     req_tready,
    output logic [127:0]        m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    input  logic [127:0]        s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [127:0]        rsp_tdata,
    output logic [NREQ-1:0]     rsp_tvalid,
    input  logic [NREQ-1:0]     rsp_tready,
    output logic                busy
);

    localparam int GW = (NREQ > 1)      ? $clog2(NREQ)      : 1;
    localparam int BW = (JOB_BEATS > 1) ? $clog2(JOB_BEATS) : 1;
    localparam int OW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(JOB_BEATS - 1);
    localparam logic [OW-1:0] LAST_OUT  = OW'(OUT_BEATS - 1);
    localparam logic [GW-1:0] LAST_REQ  = GW'(NREQ - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(TAG_DEPTH);

    typedef enum logic {IDLE, XFER} state_t;

    state_t        state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] grant_d;
    logic [GW-1:0] rr_ptr_q;
    logic [BW-1:0] beat_cnt_q;
    logic [OW-1:0] out_cnt_q;

    logic [GW-1:0] tag_mem_q [TAG_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   tag_cnt_q;

    logic [127:0]  req_beat [NREQ];
    logic [GW-1:0] head_tag;
    logic          tag_empty;
    logic          tag_full;
    logic          m_fire;
    logic          s_fire;
    logic          push;
    logic          pop;

    // Unpacked view of the flat requester bus, so the mux can index it by grant.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_beat[i] = req_tdata[i*128 +: 128];
        end
    end

    // Round-robin pick: the first requester with tvalid, scanning cyclically
    // from rr_ptr.
    always_comb begin
        int   idx;
        logic found;
        grant_d = rr_ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_tvalid[idx]) begin
                found   = 1'b1;
                grant_d = GW'(idx);
            end
        end
    end

    assign tag_empty = (tag_cnt_q == '0);
    assign tag_full  = (tag_cnt_q == FULL_CNT);
    assign head_tag  = tag_mem_q[rd_ptr_q];

    assign m_fire = (state_q == XFER) && req_tvalid[grant_q] && m_tready;
    assign s_fire = !tag_empty && s_tvalid && rsp_tready[head_tag];
    assign pop    = s_fire && (out_cnt_q == LAST_OUT);
    // A pop on the same edge frees a slot. A full FIFO can therefore still
    // accept a new job here, and its occupancy stays full.
    assign push   = (state_q == IDLE) && (|req_tvalid) && (!tag_full || pop);

    // Pure combinational routing: no latency is added on either path.
    always_comb begin
        // NOTE: each output is given a default before any condition, so no path leaves it unassigned and no latch is inferred.
        req_tready = '0;
        m_tdata    = '0;
        m_tvalid   = 1'b0;
        rsp_tvalid = '0;
        s_tready   = 1'b0;
        if (state_q == XFER) begin
            m_tdata             = req_beat[grant_q];
            m_tvalid            = req_tvalid[grant_q];
            req_tready[grant_q] = m_tready;
        end
        if (!tag_empty) begin
            rsp_tvalid[head_tag] = s_tvalid;
            s_tready             = rsp_tready[head_tag];
        end
    end

    assign rsp_tdata = s_tdata;
    assign busy      = (state_q == XFER) || !tag_empty;

    // Input FSM, round-robin pointer, beat/result counters and FIFO
    // bookkeeping.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            out_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_cnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values regardless of statement order.
            case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q    <= XFER;
                        grant_q    <= grant_d;
                        beat_cnt_q <= '0;
                    end
                end
                XFER: begin
                    if (m_fire) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q    <= IDLE;
                            beat_cnt_q <= '0;
                            rr_ptr_q   <= (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (s_fire) begin
                out_cnt_q <= pop ? '0 : out_cnt_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    // NOTE: tag storage is deliberately not reset; pointers and count are, so an entry is never read before it is written.
    always_ff @(posedge clk_core) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_d;
        end
    end

endmodule

// File: tb/tb_acc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_acc_rr_arbiter
//
// Directed bench for acc_rr_arbiter. It uses a tag depth of 2, so the
// full-FIFO cases are easy to reach.
//
// Each requester holds a queue of beats. The accelerator model returns the
// bitwise inverse of every beat, in order. Whenever an input beat is accepted,
// the expected result (owner, ~beat) is pushed onto a scoreboard queue. That
// entry is popped and compared when the matching result handshake occurs.
// ---------------------------------------------------------------------------
module tb_acc_rr_arbiter;

    localparam int NREQ = 4;
    localparam int JB   = 16;
    localparam int OB   = 16;
    localparam int TD   = 2;

    logic                clk_core = 1'b0;
    logic                rst_core = 1'b0;
    logic [NREQ*128-1:0] req_tdata;
    logic [NREQ-1:0]     req_tvalid;
    logic [NREQ-1:0]     req_tready;
    logic [127:0]        m_tdata;
    logic                m_tvalid;
    logic                m_tready;
    logic [127:0]        s_tdata;
    logic                s_tvalid;
    logic                s_tready;
    logic [127:0]        rsp_tdata;
    logic [NREQ-1:0]     rsp_tvalid;
    logic [NREQ-1:0]     rsp_tready;
    logic                busy;

    acc_rr_arbiter #(
        .NREQ(NREQ), .JOB_BEATS(JB), .OUT_BEATS(OB), .TAG_DEPTH(TD)
    ) dut (
        .clk_core(clk_core), .rst_core(rst_core),
        .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
        .busy(busy)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        int           who;
        logic [127:0] data;
    } exp_t;

    logic [127:0] req_q [NREQ][$];
    logic [127:0] acc_q [$];
    exp_t         exp_q [$];
    int           job_log [$];
    int           rsp_cnt [NREQ];

    int n_assert   = 0;
    int n_fail     = 0;
    int m_duty     = 100;
    int s_duty     = 100;
    int r_duty     = 100;
    int s_budget   = -1;
    int job_beat   = 0;
    int job_owner  = 0;
    int idle_run   = 0;
    bit bubble_chk = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] pat(input int who, input int job, input int beat);
        return {32'hA000_0000 + 32'(who), 32'(job), 32'(beat), 32'h5EED_0000 ^ 32'(who * 97 + beat)};
    endfunction

    task automatic load_job(input int who, input int job);
        for (int b = 0; b < JB; b++) req_q[who].push_back(pat(who, job, b));
    endtask

    function automatic bit pending();
        bit p = (acc_q.size() > 0) || (exp_q.size() > 0);
        for (int i = 0; i < NREQ; i++) if (req_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    // Applies the next set of stimulus: requester heads, random readiness,
    // and the accelerator output.
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_tvalid[i]           = (req_q[i].size() > 0);
            req_tdata[i*128 +: 128] = (req_q[i].size() > 0) ? req_q[i][0] : '0;
            rsp_tready[i]           = ($urandom_range(99) < r_duty);
        end
        m_tready = ($urandom_range(99) < m_duty);
        s_tvalid = (acc_q.size() > 0) && (s_budget != 0) && ($urandom_range(99) < s_duty);
        s_tdata  = (acc_q.size() > 0) ? ~acc_q[0] : '0;
    endtask

    // Looks at the handshakes that the next rising edge will complete.
    task automatic monitor();
        int               src;
        exp_t             e;
        logic [NREQ-1:0]  ev;
        logic [127:0]     beat;
        check("tready_onehot0", 128'($countones(req_tready) <= 1), 128'(1));
        if (m_tvalid && m_tready) begin
            src = -1;
            for (int i = 0; i < NREQ; i++) if (req_tready[i]) src = i;
            check("m_src_found", 128'(src >= 0), 128'(1));
            if (src >= 0) begin
                check("m_src_has_beat", 128'(req_q[src].size() > 0), 128'(1));
                if (req_q[src].size() > 0) begin
                    beat = req_q[src].pop_front();
                    check("m_tdata", m_tdata, beat);
                    acc_q.push_back(m_tdata);
                    e.who  = src;
                    e.data = ~beat;
                    exp_q.push_back(e);
                    if (job_beat == 0) begin
                        if (bubble_chk && job_log.size() > 0) check("bubble_cycles", 128'(idle_run), 128'(1));
                        job_log.push_back(src);
                        job_owner = src;
                    end else begin
                        check("no_interleave", 128'(src), 128'(job_owner));
                    end
                    job_beat = (job_beat + 1) % JB;
                end
            end
            idle_run = 0;
        end else begin
            idle_run++;
        end

        if (s_tvalid && exp_q.size() > 0) begin
            e  = exp_q[0];
            ev = '0;
            ev[e.who] = 1'b1;
            check("rsp_route", 128'(rsp_tvalid), 128'(ev));
            check("s_tready_owner", 128'(s_tready), 128'(rsp_tready[e.who]));
            if (s_tready) begin
                check("rsp_tdata", rsp_tdata, e.data);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                rsp_cnt[e.who]++;
                if (s_budget > 0) s_budget--;
            end
        end else if (!s_tvalid) begin
            check("rsp_quiet", 128'(rsp_tvalid), 128'(0));
        end
    endtask

    task automatic step();
        @(negedge clk_core);
        monitor();
        @(posedge clk_core);
        #1;
        drive();
    endtask

    task automatic drain(input int max_cyc, input string tag);
        int n = 0;
        while (pending() && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_drain_in_time"}, 128'(pending()), 128'(0));
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            req_q[i].delete();
            rsp_cnt[i] = 0;
        end
        acc_q.delete();
        exp_q.delete();
        job_log.delete();
        job_beat = 0;
        idle_run = 0;
        s_budget = -1;
    endtask

    task automatic do_reset();
        rst_core = 1'b1;
        clear_model();
        drive();
        repeat (2) @(posedge clk_core);
        #1;
        rst_core = 1'b0;
        drive();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // ---------------- reset values, with busy inputs ----------------
        req_tvalid = '1;
        for (int i = 0; i < NREQ; i++) req_tdata[i*128 +: 128] = pat(i, 9, 9);
        m_tready   = 1'b1;
        s_tvalid   = 1'b1;
        s_tdata    = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
        rsp_tready = '1;
        #2 rst_core = 1'b1;
        @(posedge clk_core);
        #1;
        check("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        check("rst_req_tready", 128'(req_tready), 128'(0));
        check("rst_s_tready", 128'(s_tready), 128'(0));
        check("rst_rsp_tvalid", 128'(rsp_tvalid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_m_tdata", m_tdata, 128'(0));
        check("rst_rsp_tdata", rsp_tdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0);
        do_reset();

        // ---------------- single job from requester 0 ----------------
        load_job(0, 0);
        drive();
        repeat (3) step();
        check("single_busy_mid", 128'(busy), 128'(1));
        drain(200, "single");
        check("single_busy_end", 128'(busy), 128'(0));
        check("single_rsp0", 128'(rsp_cnt[0]), 128'(16));
        check("single_rsp_other", 128'(rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3]), 128'(0));
        check("single_grant", 128'(job_log[0]), 128'(0));

        // ---------------- all four requesters contending ----------------
        do_reset();
        load_job(0, 0); load_job(0, 1);
        load_job(1, 0); load_job(2, 0); load_job(3, 0);
        bubble_chk = 1'b1;
        drive();
        drain(600, "rr");
        bubble_chk = 1'b0;
        check("rr_jobs", 128'(job_log.size()), 128'(5));
        if (job_log.size() == 5) begin
            check("rr_order0", 128'(job_log[0]), 128'(0));
            check("rr_order1", 128'(job_log[1]), 128'(1));
            check("rr_order2", 128'(job_log[2]), 128'(2));
            check("rr_order3", 128'(job_log[3]), 128'(3));
            check("rr_order4", 128'(job_log[4]), 128'(0));
        end

        // ---------------- tag FIFO full, then push coinciding with pop ----------------
        do_reset();
        s_budget = 0;
        for (int i = 0; i < NREQ; i++) load_job(i, 2);
        drive();
        repeat (80) step();
        check("full_jobs_started", 128'(job_log.size()), 128'(2));
        check("full_third_waits", 128'(req_q[2].size()), 128'(JB));
        check("full_idle_m_tvalid", 128'(m_tvalid), 128'(0));
        check("full_busy", 128'(busy), 128'(1));
        s_budget = OB;
        n = 0;
        while (s_budget != 0 && n < 100) begin
            step();
            n++;
        end
        check("full_pop_in_time", 128'(s_budget), 128'(0));
        #1;
        check("full_third_granted", 128'(req_tready), 128'(4'b0100));
        n = 0;
        while (req_q[2].size() > 0 && n < 100) begin
            step();
            n++;
        end
        repeat (10) step();
        check("full_stays_full", 128'(req_q[3].size()), 128'(JB));
        s_budget = -1;
        drain(400, "full");
        check("full_jobs_total", 128'(job_log.size()), 128'(4));
        if (job_log.size() == 4) check("full_last_job", 128'(job_log[3]), 128'(3));
        for (int i = 0; i < NREQ; i++) check("full_rsp_cnt", 128'(rsp_cnt[i]), 128'(OB));

        // ---------------- random back-pressure, three requesters ----------------
        clear_model();
        m_duty = 75; s_duty = 75; r_duty = 75;
        load_job(0, 3); load_job(1, 3); load_job(3, 3);
        load_job(0, 4); load_job(1, 4); load_job(3, 4);
        drive();
        drain(4000, "rand");
        check("rand_rsp0", 128'(rsp_cnt[0]), 128'(2 * OB));
        check("rand_rsp1", 128'(rsp_cnt[1]), 128'(2 * OB));
        check("rand_rsp2", 128'(rsp_cnt[2]), 128'(0));
        check("rand_rsp3", 128'(rsp_cnt[3]), 128'(2 * OB));
        m_duty = 100; s_duty = 100; r_duty = 100;

        // ---------------- reset pulsed mid-job ----------------
        clear_model();
        load_job(2, 5);
        drive();
        drain(200, "pre_abort");
        load_job(0, 6);
        drive();
        n = 0;
        while (job_beat != 7 && n < 100) begin
            step();
            n++;
        end
        check("abort_reached_beat7", 128'(job_beat), 128'(7));
        rst_core = 1'b1;
        #1;
        check("abort_m_tvalid", 128'(m_tvalid), 128'(0));
        check("abort_req_tready", 128'(req_tready), 128'(0));
        check("abort_s_tready", 128'(s_tready), 128'(0));
        check("abort_rsp_tvalid", 128'(rsp_tvalid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_m_tdata", m_tdata, 128'(0));
        check("abort_rsp_tdata", rsp_tdata, s_tdata);
        clear_model();
        drive();
        @(posedge clk_core);
        #1;
        rst_core = 1'b0;
        load_job(2, 7); load_job(3, 7);
        drive();
        n = 0;
        while (job_log.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check("abort_next_started", 128'(job_log.size() > 0), 128'(1));
        if (job_log.size() > 0) check("abort_next_grant", 128'(job_log[0]), 128'(2));
        drain(400, "post_abort");
        check("post_abort_rsp2", 128'(rsp_cnt[2]), 128'(OB));
        check("post_abort_rsp3", 128'(rsp_cnt[3]), 128'(OB));
        check("post_abort_idle", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
